// File: rtl/fpmulti_pkg.sv
// fpmulti_pkg: shared sizing defaults and index-width helper for the FP multiplier arbiter
package fpmulti_pkg;
  localparam int N_DEF = 4;
  localparam int FP_W_DEF = 32;
  localparam int MUL_LAT_DEF = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fpmulti_arbiter_rr.sv
// rr_arbiter: combinational one-hot round-robin grant, search starts at i_ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_elig,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  logic [IDX_W-1:0] w_j;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j = '0;
    // scan farthest offset first so the closest eligible index to i_ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IDX_W'((int'(i_ptr) + k) % N);
      if (i_elig[w_j]) begin
        o_grant = '0;
        o_grant[w_j] = 1'b1;
        o_idx = w_j;
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpmulti_arbiter.sv
// fpmulti_arbiter: round-robin sharing of one pipelined FP multiplier among N requesters
module fpmulti_arbiter
  import fpmulti_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int FP_W = FP_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N-1:0]      i_req_valid,
  output logic [N-1:0]      o_req_ready,
  input  logic [N*FP_W-1:0] i_req_a,
  input  logic [N*FP_W-1:0] i_req_b,
  output logic [N-1:0]      o_rsp_valid,
  input  logic [N-1:0]      i_rsp_ready,
  output logic [N*FP_W-1:0] o_rsp_data,
  output logic [FP_W-1:0]   o_mul_a,
  output logic [FP_W-1:0]   o_mul_b,
  input  logic [FP_W-1:0]   i_mul_out
);
  localparam int IDX_W = idx_w(N);
  logic [N-1:0] w_elig, w_grant, w_hs, w_cap, r_pending, r_rsp_valid;
  logic [IDX_W-1:0] w_idx, r_ptr;
  logic w_any;
  logic [IDX_W:0] r_tag [MUL_LAT];
  logic [N*FP_W-1:0] r_rsp_data;
  logic [FP_W-1:0] r_mul_a, r_mul_b;
  assign w_elig = i_req_valid & ~r_pending;
  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_rr (
    .i_elig(w_elig),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign o_req_ready = i_rst_n ? w_grant : '0;
  assign w_hs = r_rsp_valid & i_rsp_ready;
  assign w_cap = r_tag[MUL_LAT-1][IDX_W] ? N'(1) << r_tag[MUL_LAT-1][IDX_W-1:0] : '0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data = r_rsp_data;
  assign o_mul_a = r_mul_a;
  assign o_mul_b = r_mul_b;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_rsp_valid <= '0;
      r_rsp_data <= '0;
      r_pending <= '0;
      r_ptr <= '0;
      for (int k = 0; k < MUL_LAT; k++) r_tag[k] <= '0;
    end else begin
      // grant and handshake never hit the same index: a held response keeps its owner pending
      r_pending <= (r_pending | w_grant) & ~w_hs;
      r_rsp_valid <= (r_rsp_valid & ~w_hs) | w_cap;
      r_tag[0] <= {w_any, w_idx};
      for (int k = 1; k < MUL_LAT; k++) r_tag[k] <= r_tag[k-1];
      for (int k = 0; k < N; k++) if (w_cap[k]) r_rsp_data[k*FP_W +: FP_W] <= i_mul_out;
      if (w_any) begin
        r_mul_a <= i_req_a[int'(w_idx)*FP_W +: FP_W];
        r_mul_b <= i_req_b[int'(w_idx)*FP_W +: FP_W];
        r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end
endmodule
